mem_bank: RTL and testbench

Parametrised single-port word memory built from the bitcell behaviour: `sel`/`rw` select and direction per access, generalised to `DEPTH` words of `DATA_W` bits. Reads are registered and flagged by a one-cycle valid pulse. A hardware clear sweep zeroes the whole array without host writes. The block is the storage primitive for the memory subsystem, driven directly by the controller above it.

---
 rtl/mem_bank_if.sv | 28 ++
 rtl/mem_bank.sv | 125 ++++++++++++
 tb/tb_mem_bank.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_if.sv
// mem_bank_if: host-side access bus of mem_bank.
//   master (controller) drives: sel, rw, addr, inp, clr
//   slave  (mem_bank)   drives: outp, outp_valid, err, busy
// DATA_W / ADDR_W must match the attached mem_bank instance.
interface mem_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              sel;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] inp;
  logic              clr;
  logic [DATA_W-1:0] outp;
  logic              outp_valid;
  logic              err;
  logic              busy;

  modport master (
    output sel, rw, addr, inp, clr,
    input  outp, outp_valid, err, busy
  );

  modport slave (
    input  sel, rw, addr, inp, clr,
    output outp, outp_valid, err, busy
  );
endinterface

// File: rtl/mem_bank.sv
// mem_bank: single-port DEPTH x DATA_W word memory with registered reads
// and a hardware clear sweep.
//   clk            rising-edge clock
//   rst            asynchronous active-high reset (outputs/FSM only, not the array)
//   bus.sel/rw     access request / direction (1 = write)
//   bus.addr/inp   word address / write data
//   bus.clr        start a clear sweep (sampled in IDLE only, beats sel)
//   bus.outp       last read data, bus.outp_valid one-cycle read pulse
//   bus.err        one-cycle pulse on access to addr >= DEPTH
//   bus.busy       high while the clear sweep runs (exactly DEPTH cycles)
module mem_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  mem_bank_if.slave   bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so DEPTH itself is representable for the range check.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] outp_q, outp_d;
  logic              outp_valid_q, outp_valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              in_range;
  logic [DATA_W-1:0] rdata;

  assign in_range = ({1'b0, bus.addr} < DEPTH_L);
  // Never index past the array; out-of-range reads return zero anyway.
  assign rdata    = in_range ? mem_q[bus.addr] : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    outp_d       = outp_q;
    outp_valid_d = 1'b0;
    err_d        = 1'b0;
    busy_d       = busy_q;
    mem_we       = 1'b0;
    mem_waddr    = bus.addr;
    mem_wdata    = bus.inp;
    unique case (state_q)
      IDLE: begin
        if (bus.clr) begin
          // clr wins: any same-cycle access is dropped entirely.
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (bus.sel) begin
          if (in_range) begin
            if (bus.rw) begin
              mem_we = 1'b1;
            end else begin
              outp_d       = rdata;
              outp_valid_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
            if (!bus.rw) begin
              outp_d       = '0;
              outp_valid_d = 1'b1;
            end
          end
        end
      end
      CLEAR: begin
        // Bus is ignored; sweep one word per cycle.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;   // counter holds at LAST, never wraps
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      outp_q       <= '0;
      outp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      outp_q       <= outp_d;
      outp_valid_q <= outp_valid_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  // Array has no reset. Reset forces the FSM out of CLEAR asynchronously,
  // so an aborted sweep stops writing immediately.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.outp       = outp_q;
  assign bus.outp_valid = outp_valid_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: directed + random checks of mem_bank against an array model.
// dut_a (DEPTH 16) and dut_b (DEPTH 10, ADDR_W 4) share one stimulus bus;
// dut_c (DATA_W 1, DEPTH 2) replays the bitcell sequence.
module tb_mem_bank;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bank_if #(.DATA_W(8), .ADDR_W(4)) ifa ();
  mem_bank_if #(.DATA_W(8), .ADDR_W(4)) ifb ();
  mem_bank_if #(.DATA_W(1), .ADDR_W(1)) ifc ();

  assign ifb.sel  = ifa.sel;
  assign ifb.rw   = ifa.rw;
  assign ifb.addr = ifa.addr;
  assign ifb.inp  = ifa.inp;
  assign ifb.clr  = ifa.clr;

  mem_bank #(.DATA_W(8), .DEPTH(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mem_bank #(.DATA_W(8), .DEPTH(10)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  mem_bank #(.DATA_W(1), .DEPTH(2))  dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  int total = 0;
  int bad   = 0;

  // Reference model: k=0 -> dut_a, k=1 -> dut_b.
  logic [7:0] m_mem  [2][16];
  bit         m_busy [2];
  int         m_left [2];   // words still to be zeroed by the sweep
  logic [7:0] m_outp [2];
  bit         m_vld  [2];
  bit         m_err  [2];
  int         m_depth[2] = '{16, 10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    check("a_outp",  32'(ifa.outp),       32'(m_outp[0]));
    check("a_valid", 32'(ifa.outp_valid), 32'(m_vld[0]));
    check("a_err",   32'(ifa.err),        32'(m_err[0]));
    check("a_busy",  32'(ifa.busy),       32'(m_busy[0]));
    check("b_outp",  32'(ifb.outp),       32'(m_outp[1]));
    check("b_valid", 32'(ifb.outp_valid), 32'(m_vld[1]));
    check("b_err",   32'(ifb.err),        32'(m_err[1]));
    check("b_busy",  32'(ifb.busy),       32'(m_busy[1]));
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 1'b0;
      m_err[k] = 1'b0;
      if (m_busy[k]) begin
        m_mem[k][m_depth[k] - m_left[k]] = 8'h00;
        m_left[k]--;
        if (m_left[k] == 0) m_busy[k] = 1'b0;
      end else if (ifa.clr) begin
        m_busy[k] = 1'b1;
        m_left[k] = m_depth[k];
      end else if (ifa.sel) begin
        if (int'(ifa.addr) < m_depth[k]) begin
          if (ifa.rw) m_mem[k][ifa.addr] = ifa.inp;
          else begin
            m_outp[k] = m_mem[k][ifa.addr];
            m_vld[k]  = 1'b1;
          end
        end else begin
          m_err[k] = 1'b1;
          if (!ifa.rw) begin
            m_outp[k] = 8'h00;
            m_vld[k]  = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic drive(input bit s, input bit w, input logic [3:0] a, input logic [7:0] d, input bit c);
    ifa.sel = s; ifa.rw = w; ifa.addr = a; ifa.inp = d; ifa.clr = c;
  endtask

  task automatic cdrive(input bit s, input bit w, input bit a, input bit d);
    ifc.sel = s; ifc.rw = w; ifc.addr = a; ifc.inp = d; ifc.clr = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_mem[k][i] = 8'hxx;
      m_busy[k] = 0; m_left[k] = 0; m_outp[k] = 8'h00; m_vld[k] = 0; m_err[k] = 0;
    end
    rst = 1'b1;
    drive(0, 0, 4'd0, 8'h00, 0);
    cdrive(0, 0, 0, 0);
    #12;
    check_outs();
    check("c_outp_rst",  32'(ifc.outp),       32'd0);
    check("c_valid_rst", 32'(ifc.outp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Initial clear sweep, then every word reads back zero.
    drive(0, 0, 4'd0, 8'h00, 1);
    cycle();
    drive(0, 0, 4'd0, 8'h00, 0);
    repeat (16) cycle();
    check("a_busy_after_16", 32'(ifa.busy), 32'd0);
    for (int a = 0; a < 16; a++) begin
      drive(1, 0, 4'(a), 8'h00, 0);
      cycle();
    end

    // Write then read, then idle holds outp.
    drive(1, 1, 4'd3, 8'hA5, 0); cycle();
    drive(1, 0, 4'd3, 8'h00, 0); cycle();
    check("a_rd3", 32'(ifa.outp), 32'hA5);
    drive(0, 0, 4'd3, 8'h00, 0); cycle();
    check("a_hold3", 32'(ifa.outp), 32'hA5);

    // addr 12: in range for dut_a, out of range for dut_b.
    drive(1, 1, 4'd12, 8'hFF, 0); cycle();
    check("b_err_wr12", 32'(ifb.err), 32'd1);
    drive(1, 0, 4'd12, 8'h00, 0); cycle();
    check("b_rd12", 32'(ifb.outp), 32'd0);
    for (int a = 0; a < 10; a++) begin
      drive(1, 0, 4'(a), 8'h00, 0);
      cycle();
    end

    // clr beats a same-cycle write; reads during busy give no valid.
    drive(1, 1, 4'd5, 8'h3C, 1); cycle();
    check("a_busy_clr", 32'(ifa.busy), 32'd1);
    drive(1, 0, 4'd5, 8'h00, 0);
    repeat (16) cycle();
    cycle();
    check("a_rd5_cleared", 32'(ifa.outp), 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 49) == 0);
      cycle();
    end
    drive(0, 0, 4'd0, 8'h00, 0);
    repeat (16) cycle();

    // Fill with 0x5A, clear, abort by reset after four swept words.
    for (int a = 0; a < 16; a++) begin
      drive(1, 1, 4'(a), 8'h5A, 0);
      cycle();
    end
    drive(1, 0, 4'd0, 8'h00, 0);
    cycle();
    drive(0, 0, 4'd0, 8'h00, 1); cycle();
    drive(0, 0, 4'd0, 8'h00, 0);
    repeat (4) cycle();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_left[k] = 0; m_outp[k] = 8'h00; m_vld[k] = 0; m_err[k] = 0;
    end
    check_outs();
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      drive(1, 0, 4'(a), 8'h00, 0);
      cycle();
      if (a == 3) check("a_rd3_swept", 32'(ifa.outp), 32'd0);
      if (a == 4) check("a_rd4_kept",  32'(ifa.outp), 32'h5A);
    end
    drive(0, 0, 4'd0, 8'h00, 0);

    // Bitcell replay on the 1-bit, 2-word instance.
    cdrive(1, 1, 0, 1); cycle();
    cdrive(1, 0, 0, 0); cycle();
    check("c_rd1",   32'(ifc.outp),       32'd1);
    check("c_vld1",  32'(ifc.outp_valid), 32'd1);
    cdrive(1, 1, 0, 0); cycle();
    check("c_vld_wr", 32'(ifc.outp_valid), 32'd0);
    cdrive(1, 0, 0, 0); cycle();
    check("c_rd0",   32'(ifc.outp),       32'd0);
    check("c_vld0",  32'(ifc.outp_valid), 32'd1);
    cdrive(0, 1, 0, 1); cycle();
    check("c_idle_vld",  32'(ifc.outp_valid), 32'd0);
    check("c_idle_hold", 32'(ifc.outp),       32'd0);
    cdrive(1, 0, 0, 0); cycle();
    check("c_rd_after_idle", 32'(ifc.outp), 32'd0);
    check("c_err", 32'(ifc.err), 32'd0);
    cdrive(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
